// File: rtl/data_mem_bank.sv
// Word-addressed RAM with per-byte write enables and a post-reset zeroing pass (busy while clearing).
// Optional per-byte even parity with a parity_err output when DATA_MEM_PARITY_EN is defined.
module data_mem_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   write_data,
  input  logic                wren,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic [DATA_W-1:0]   read_data,
  output logic                busy,
  output logic                addr_err
`ifdef DATA_MEM_PARITY_EN
  ,
  output logic                parity_err
`endif
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;
  logic              clr_we;
  logic              usr_we;
  logic [IDX_W-1:0]  clr_idx, usr_idx;

  logic [DATA_W-1:0] mem [DEPTH];
`ifdef DATA_MEM_PARITY_EN
  logic [NB-1:0]     par [DEPTH];
`endif

  generate
    if (64'(DEPTH) < (64'd1 << ADDR_W)) begin : g_range
      assign addr_err = (address >= ADDR_W'(DEPTH));
    end else begin : g_full
      assign addr_err = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    busy         = 1'b0;
    clr_we       = 1'b0;
    case (state)
      CLEAR: begin
        busy         = 1'b1;
        clr_we       = 1'b1;
        clr_addr_nxt = clr_addr + 1'b1;
        if (clr_addr == LAST) begin
          state_nxt    = READY;
          clr_addr_nxt = '0;
        end
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign usr_we  = !busy && !wren && !addr_err;
  assign clr_idx = clr_addr[IDX_W-1:0];
  // Out-of-range addresses are steered to word 0; their effects are masked anyway.
  assign usr_idx = addr_err ? '0 : address[IDX_W-1:0];

  // Memory holds its contents while rst_n is low; the clear pass is the only initialiser.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clr_we) begin
        mem[clr_idx] <= '0;
`ifdef DATA_MEM_PARITY_EN
        par[clr_idx] <= '0;
`endif
      end else if (usr_we) begin
        for (int i = 0; i < NB; i++) begin
          if (byte_en[i]) begin
            mem[usr_idx][8*i +: 8] <= write_data[8*i +: 8];
`ifdef DATA_MEM_PARITY_EN
            par[usr_idx][i]        <= ^write_data[8*i +: 8];
`endif
          end
        end
      end
    end
  end

  always_comb begin
    read_data = '0;
    if (!busy && !addr_err) read_data = mem[usr_idx];
  end

`ifdef DATA_MEM_PARITY_EN
  logic [DATA_W-1:0] raw_word;
  logic [NB-1:0]     raw_par;

  assign raw_word = mem[usr_idx];
  assign raw_par  = par[usr_idx];

  always_comb begin
    parity_err = 1'b0;
    if (!busy && !addr_err) begin
      for (int i = 0; i < NB; i++) begin
        if (raw_par[i] != ^raw_word[8*i +: 8]) parity_err = 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/data_mem_bank.md
Name: data_mem_bank

Overview:
Parametrised successor to the CPU's 256x8 data memory. Word-addressed RAM with generic data width and depth and per-byte write enables, and an active-low write strobe with unchanged meaning. A self-clearing state machine zeroes every word after reset, with a busy flag during the clear. Out-of-range addresses are flagged. Sits on the CPU data path in place of the fixed 8-bit memory, with the same single-cycle write and combinational read timing.

Parameters:
DATA_W, 32, word width in bits; a multiple of 8.
ADDR_W, 8, address width in bits.
DEPTH, 256, number of words; 1 <= DEPTH <= 2**ADDR_W.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous, active-low reset, sampled on the clk rising edge.
address  input  ADDR_W  word address for the read and the write.
write_data  input  DATA_W  write data.
wren  input  1  write strobe, active low (0 = write).
byte_en  input  DATA_W/8  per-byte write mask, active high; bit i covers write_data[8i+7:8i].
read_data  output  DATA_W  combinational read of mem[address].
busy  output  1  high while the post-reset clear runs.
addr_err  output  1  combinational; high when address >= DEPTH.

Behaviour:
- Reset (rst_n = 0 at an edge):
  - clr_addr <= 0; busy <= 1.
  - Memory contents are not touched while rst_n is held low.
  - No user write happens during reset.
- Clear FSM, states CLEAR and READY:
  - Reset enters CLEAR.
  - In CLEAR, each edge with rst_n = 1 writes mem[clr_addr] <= 0 and then clr_addr <= clr_addr + 1.
  - At the edge that writes clr_addr = DEPTH-1: busy <= 0, state <= READY.
  - busy is therefore high for exactly DEPTH cycles after reset release.
- Reset mid-clear: the clear restarts from address 0. Partial progress is discarded and busy stays high.
- Busy gating:
  - While busy = 1, user writes are ignored regardless of wren and byte_en.
  - While busy = 1, read_data = 0.
- Write (READY): at an edge with wren = 0 and address < DEPTH, mem[address] byte i <= write_data byte i for each i where byte_en[i] = 1. Other bytes are unchanged.
  - byte_en = 0 with wren = 0 is a no-op.
- Read (READY): read_data = mem[address] combinationally, with zero cycles of latency.
  - Read-during-write to the same address shows old data before the edge and new data after it.
- Out of range (address >= DEPTH):
  - addr_err = 1.
  - Writes are dropped and read_data = 0.
  - addr_err is valid during busy too.
  - With DEPTH = 2**ADDR_W, addr_err is constantly 0.
- Reset values: busy = 1; read_data = 0 (forced by busy); addr_err follows address.
- Memory is not reset-cleared in one cycle. The clear FSM is the only initialisation path; there is no initial-block preload.

Optional Feature:
Macro DATA_MEM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte beside the data.
  - A write computes and stores the parity of each enabled byte. The clear stores parity 0 for zero data.
  - Extra output parity_err (1 bit, combinational) = OR over bytes of (stored parity != recomputed parity of the read byte).
  - parity_err is 0 while busy or addr_err.
  - A hidden test hook is not provided; corruption is injected by the bench via hierarchical force.
- Undefined: no parity storage and no parity_err port. All other behaviour is identical.

Test Plan:
- DEPTH=16, DATA_W=32. Release rst_n after 2 cycles -> busy = 1 for exactly 16 cycles, then 0. Reading every address 0..15 returns 32'h00000000.
- After clear: write address 3, data 32'hA1B2C3D4, byte_en 4'hF, wren = 0, then wren = 1 -> read_data at address 3 = 32'hA1B2C3D4 the cycle after the edge. Address 4 still reads 0.
- On address 3 write data 32'h11223344 with byte_en 4'b0101 -> read_data = 32'hA122C344. Same data with wren = 1 -> no change.
- Write address 5 = 32'hDEADBEEF while busy (during the clear), then wait for READY -> address 5 reads 0. Assert rst_n low at clear cycle 7 -> busy runs a full 16 cycles after re-release.
- DEPTH=12, ADDR_W=4: address 13, wren = 0, data 32'hFFFFFFFF -> addr_err = 1, read_data = 0, and no word 0..11 changes.
- With DATA_MEM_PARITY_EN: write 32'h01020304, then force one stored data bit of byte 0 -> parity_err = 1. Rewriting the word -> parity_err = 0.
